// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine.
// State encoding, default operand width and a flag-validity helper.
package sar_pkg;

    localparam int SAR_WIDTH_DEF = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SEARCH = 1'b1
    } sar_state_t;

    // Comparator flags are only meaningful when exactly one is set.
    function automatic logic flags_onehot(
        input logic g,
        input logic l,
        input logic e
    );
        return ({g, l, e} == 3'b100) ||
               ({g, l, e} == 3'b010) ||
               ({g, l, e} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives trial into an external comparator
// and recovers operand A MSB first, exiting early on equality.
// Ports: clk, rst (sync, active-high), start; cmp_greater/lesser/equal flags in;
//        trial, busy, done (1-cycle pulse), result, err, iters out.
module sar_search
    import sar_pkg::*;
#(
    parameter  int WIDTH = SAR_WIDTH_DEF,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_greater,
    input  logic             cmp_lesser,
    input  logic             cmp_equal,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [CW-1:0]    iters
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_t       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    // One-hot pointer to the bit currently under test.
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             err_q,   err_d;
    logic [CW-1:0]    iters_q, iters_d;

    logic [WIDTH-1:0] v;
    logic             valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            trial_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            iters_q <= '0;
        end else begin
            state_q <= state_d;
            trial_q <= trial_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            err_q   <= err_d;
            iters_q <= iters_d;
        end
    end

    // Bit under test is kept when A is greater, dropped when A is lesser.
    assign valid = flags_onehot(cmp_greater, cmp_lesser, cmp_equal);
    assign v     = cmp_greater ? trial_q : (trial_q & ~mask_q);

    always_comb begin
        state_d = state_q;
        trial_d = trial_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        res_d   = res_q;
        err_d   = err_q;
        iters_d = iters_q;

        unique case (state_q)
            S_IDLE: begin
                trial_d = '0;
                if (start) begin
                    state_d = S_SEARCH;
                    trial_d = MSB;
                    mask_d  = MSB;
                    cnt_d   = CW'(1);
                end
            end
            S_SEARCH: begin
                if (!valid) begin
                    state_d = S_IDLE;
                    trial_d = '0;
                    err_d   = 1'b1;
                    res_d   = '0;
                    iters_d = cnt_q;
                    done_d  = 1'b1;
                end else if (cmp_equal) begin
                    state_d = S_IDLE;
                    trial_d = '0;
                    err_d   = 1'b0;
                    res_d   = trial_q;
                    iters_d = cnt_q;
                    done_d  = 1'b1;
                end else if (mask_q[0]) begin
                    state_d = S_IDLE;
                    trial_d = '0;
                    err_d   = 1'b0;
                    res_d   = v;
                    iters_d = cnt_q;
                    done_d  = 1'b1;
                end else begin
                    trial_d = v | (mask_q >> 1);
                    mask_d  = mask_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                trial_d = '0;
            end
        endcase
    end

    assign trial  = trial_q;
    assign busy   = (state_q == S_SEARCH);
    assign done   = done_q;
    assign result = res_q;
    assign err    = err_q;
    assign iters  = iters_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search at WIDTH=8 and WIDTH=2.
// Reference model derives trial sequences and iteration counts arithmetically.
module tb_sar_search;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic [7:0] a8 = '0;
    logic [1:0] a2 = '0;
    logic       frc = 1'b0;
    logic [2:0] fflags = '0;

    logic [7:0] trial8, result8;
    logic [3:0] iters8;
    logic       busy8, done8, err8;
    logic       g8, l8, e8;

    logic [1:0] trial2, result2;
    logic [1:0] iters2;
    logic       busy2, done2, err2;
    logic       g2, l2, e2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign g8 = frc ? fflags[2] : (a8 > trial8);
    assign l8 = frc ? fflags[1] : (a8 < trial8);
    assign e8 = frc ? fflags[0] : (a8 == trial8);

    assign g2 = a2 > trial2;
    assign l2 = a2 < trial2;
    assign e2 = a2 == trial2;

    sar_search #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start),
        .cmp_greater(g8), .cmp_lesser(l8), .cmp_equal(e8),
        .trial(trial8), .busy(busy8), .done(done8),
        .result(result8), .err(err8), .iters(iters8)
    );

    sar_search #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .cmp_greater(g2), .cmp_lesser(l2), .cmp_equal(e2),
        .trial(trial2), .busy(busy2), .done(done2),
        .result(result2), .err(err2), .iters(iters2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Search ends when the lowest set bit of A is the bit under test.
    function automatic int exp_iters(input int a, input int w);
        int tz;
        if (a == 0) return w;
        tz = 0;
        while (((a >> tz) & 1) == 0) tz++;
        return w - tz;
    endfunction

    // Step i presents A's top i-1 bits plus a 1 at bit w-i.
    function automatic int exp_trial(input int a, input int w, input int i);
        int sh;
        sh = w - i + 1;
        return ((a >> sh) << sh) | (1 << (w - i));
    endfunction

    function automatic logic [31:0] o_trial(input int sel);
        return sel != 0 ? 32'(trial2) : 32'(trial8);
    endfunction
    function automatic logic [31:0] o_res(input int sel);
        return sel != 0 ? 32'(result2) : 32'(result8);
    endfunction
    function automatic logic [31:0] o_iters(input int sel);
        return sel != 0 ? 32'(iters2) : 32'(iters8);
    endfunction
    function automatic logic o_busy(input int sel);
        return sel != 0 ? busy2 : busy8;
    endfunction
    function automatic logic o_done(input int sel);
        return sel != 0 ? done2 : done8;
    endfunction
    function automatic logic o_err(input int sel);
        return sel != 0 ? err2 : err8;
    endfunction

    // One full search; poke raises start mid-search, b2b restarts on done.
    task automatic run(input int sel, input int a, input bit poke,
                       input bit b2b);
        int w, got, ei;
        w = (sel != 0) ? 2 : 8;
        if (sel != 0) a2 = 2'(a); else a8 = 8'(a);
        ei = exp_iters(a, w);
        got = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 1; i <= w; i++) begin
            chk("trial", o_trial(sel), 32'(exp_trial(a, w, i)));
            chk("busy_hi", 32'(o_busy(sel)), 32'd1);
            if (poke && i == 2) start = 1'b1;
            @(negedge clk) start = 1'b0;
            if (o_done(sel)) begin
                got = i;
                break;
            end
        end
        chk("done_cycle", 32'(got), 32'(ei));
        chk("result", o_res(sel), 32'(a));
        chk("err_lo", 32'(o_err(sel)), 32'd0);
        chk("iters", o_iters(sel), 32'(ei));
        chk("busy_lo", 32'(o_busy(sel)), 32'd0);
        chk("trial_idle", o_trial(sel), 32'd0);
        if (b2b) begin
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            chk("b2b_busy", 32'(o_busy(sel)), 32'd1);
            chk("b2b_trial", o_trial(sel), 32'(exp_trial(a, w, 1)));
            chk("b2b_done_lo", 32'(o_done(sel)), 32'd0);
            got = 0;
            for (int i = 1; i <= w; i++) begin
                @(negedge clk);
                if (o_done(sel)) begin
                    got = i;
                    break;
                end
            end
            chk("b2b_cycle", 32'(got), 32'(ei));
            chk("b2b_result", o_res(sel), 32'(a));
        end
        @(negedge clk);
        chk("done_pulse", 32'(o_done(sel)), 32'd0);
    endtask

    initial begin
        int a;
        int got;

        repeat (3) @(negedge clk);
        chk("rst_trial", 32'(trial8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_result", 32'(result8), 32'd0);
        chk("rst_err", 32'(err8), 32'd0);
        chk("rst_iters", 32'(iters8), 32'd0);
        rst = 1'b0;

        run(0, 8'h5A, 1'b0, 1'b0);
        run(0, 8'h00, 1'b0, 1'b0);
        run(0, 8'hFF, 1'b0, 1'b0);
        run(0, 8'h80, 1'b0, 1'b0);
        run(0, 8'h37, 1'b1, 1'b0);
        run(0, 8'h40, 1'b1, 1'b0);
        run(0, 8'hC4, 1'b0, 1'b1);

        // Non-one-hot flags on the third search cycle.
        a8 = 8'h5A;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        frc = 1'b1;
        fflags = 3'b000;
        @(negedge clk) frc = 1'b0;
        chk("err_done", 32'(done8), 32'd1);
        chk("err_flag", 32'(err8), 32'd1);
        chk("err_result", 32'(result8), 32'd0);
        chk("err_iters", 32'(iters8), 32'd3);
        chk("err_busy", 32'(busy8), 32'd0);
        run(0, 8'h21, 1'b0, 1'b0);

        // Reset on the fourth search cycle aborts without a done pulse.
        a8 = 8'h5A;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_trial", 32'(trial8), 32'(exp_trial(8'h5A, 8, 4)));
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_trial", 32'(trial8), 32'd0);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_result", 32'(result8), 32'd0);
        chk("abort_iters", 32'(iters8), 32'd0);
        got = 0;
        repeat (9) begin
            @(negedge clk);
            if (done8) got = 1;
        end
        chk("abort_no_done", 32'(got), 32'd0);

        for (int k = 0; k < 20; k++) begin
            a = int'($urandom_range(0, 255));
            run(0, a, k[0], 1'b0);
        end

        for (int k = 0; k < 4; k++) run(1, k, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
